// File: rtl/instr_issue_unit.sv
// Instruction issue stage: queues words, presents opcodes to the decoder, holds memory ops until mem_done.
// Optional memory-stall cycle counter enabled by defining ISSUE_STALL_CNT_EN.
module instr_issue_unit #(
    parameter int INSTR_W = 32,
    parameter int QDEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    input  logic [INSTR_W-1:0]       instr,
    output logic                     instr_ready,
    input  logic                     flush,
    output logic [5:0]               opcode,
    output logic                     opcode_valid,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic                     mem_done,
    output logic                     issued,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic [15:0]              stall_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t         state;
    logic [5:0]     opMem [QDEPTH];
    logic [PW-1:0]  headPtr;
    logic [PW-1:0]  tailPtr;
    logic           push;
    logic           pop;
    logic [CW-1:0]  nextCount;
    logic           unusedInstrBits;

    // Only the opcode field is ever consumed downstream.
    assign unusedInstrBits = ^instr[INSTR_W-7:0];

    // A full queue refuses a push even when the head retires in the same cycle.
    assign instr_ready  = (q_count < CW'(QDEPTH)) && !flush;
    assign push         = instr_valid && instr_ready;
    assign opcode_valid = (state != IDLE);
    assign issued       = pop;
    assign nextCount    = q_count + CW'(push) - CW'(pop);

    // Retire decision: decoded non-memory op in ISSUE, or completion in MEM_WAIT.
    always_comb begin
        pop = 1'b0;
        if (flush) begin
            pop = 1'b0;
        end else begin
            case (state)
                ISSUE:    pop = !(mem_read || mem_write);
                MEM_WAIT: pop = mem_done;
                default:  pop = 1'b0;
            endcase
        end
    end

    // Idle presents the NOP encoding so the decoder never sees a stale opcode.
    always_comb begin
        if (opcode_valid) begin
            opcode = opMem[headPtr];
        end else begin
            opcode = 6'h3F;
        end
    end

    // Opcode storage; lives outside reset since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            opMem[tailPtr] <= instr[INSTR_W-1 -: 6];
        end
    end

    // Issue FSM with queue pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            headPtr <= '0;
            tailPtr <= '0;
            q_count <= '0;
        end else if (flush) begin
            state   <= IDLE;
            headPtr <= '0;
            tailPtr <= '0;
            q_count <= '0;
        end else begin
            q_count <= nextCount;
            if (push) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PW'(1);
            end
            case (state)
                IDLE: begin
                    if (q_count != '0) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!pop) begin
                        state <= MEM_WAIT;
                    end else if (nextCount != '0) begin
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (pop) begin
                        state <= (nextCount != '0) ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stallCnt;

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= 16'h0000;
        end else if ((state == MEM_WAIT) && !mem_done && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'h0001;
        end
    end

    assign stall_cnt = stallCnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: hand sequences for corner cases plus a scoreboarded vector table.
module tb_instr_issue_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        flush;
    logic [5:0]  opcode;
    logic        opcode_valid;
    logic        mem_read;
    logic        mem_write;
    logic        mem_done;
    logic        issued;
    logic [2:0]  q_count;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] op;
        int         lat;
        int         expHold;
    } vec_t;

    vec_t vecs [8];
    vec_t sb [$];

`ifdef ISSUE_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL4 = 16'd4;
    localparam logic [15:0] EXP_SAT    = 16'hFFFF;
`else
    localparam logic [15:0] EXP_STALL4 = 16'd0;
    localparam logic [15:0] EXP_SAT    = 16'd0;
`endif

    instr_issue_unit #(.INSTR_W(32), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .flush(flush), .opcode(opcode),
        .opcode_valid(opcode_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_done(mem_done), .issued(issued), .q_count(q_count), .stall_cnt(stall_cnt)
    );

    // Decoder model: 0x20-0x27 are loads, 0x28-0x2F are stores, everything else is non-memory.
    assign mem_read  = (opcode[5:3] == 3'b100);
    assign mem_write = (opcode[5:3] == 3'b101);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [5:0] op);
        tick();
        instr_valid = 1'b1;
        instr       = {op, 26'($urandom)};
        #3;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((q_count != 3'd0 || opcode_valid) && n < 50) begin
            tick();
            #3;
            n++;
        end
        chk(name, {31'd0, (q_count == 3'd0) && !opcode_valid}, 32'd1);
    endtask

    // Reaches MEM_WAIT on 0x23 with 0x01 and 0x02 queued behind it (q_count = 3).
    task automatic setupMemWait3();
        pushWord(6'h23);
        pushWord(6'h01);
        pushWord(6'h02);
        tick();
        instr_valid = 1'b0;
        #3;
        chk("setup_opcode", opcode, 6'h23);
        chk("setup_count", q_count, 3'd3);
    endtask

    initial begin
        int idx;
        int hold;
        int cyc;
        int offered;

        rst = 1'b0; instr_valid = 1'b0; instr = 32'd0; flush = 1'b0; mem_done = 1'b0;
        vecs[0] = '{6'h00, 0, 1};
        vecs[1] = '{6'h01, 0, 1};
        vecs[2] = '{6'h23, 2, 3};
        vecs[3] = '{6'h05, 0, 1};
        vecs[4] = '{6'h2B, 1, 2};
        vecs[5] = '{6'h3F, 0, 1};
        vecs[6] = '{6'h10, 0, 1};
        vecs[7] = '{6'h20, 4, 5};

        #1 rst = 1'b1;
        #1;
        chk("rst_opcode", opcode, 6'h3F);
        chk("rst_valid", opcode_valid, 1'b0);
        chk("rst_count", q_count, 3'd0);
        chk("rst_issued", issued, 1'b0);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_stall", stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back non-memory ops
        pushWord(6'h00);
        tick(); instr = {6'h01, 26'd7}; #3;
        chk("b2b_lat_valid", opcode_valid, 1'b0);
        chk("b2b_lat_count", q_count, 3'd1);
        tick(); instr_valid = 1'b0; #3;
        chk("b2b_op0", opcode, 6'h00);
        chk("b2b_iss0", issued, 1'b1);
        tick(); #3;
        chk("b2b_op1", opcode, 6'h01);
        chk("b2b_iss1", issued, 1'b1);
        tick(); #3;
        chk("b2b_idle_valid", opcode_valid, 1'b0);
        chk("b2b_idle_op", opcode, 6'h3F);
        chk("b2b_idle_iss", issued, 1'b0);

        // Memory op stalled for five MEM_WAIT cycles
        pushWord(6'h23);
        tick(); instr_valid = 1'b0; #3;
        for (int i = 0; i < 6; i++) begin
            tick(); mem_done = (i == 5); #3;
            chk("mem_hold_op", opcode, 6'h23);
            chk("mem_issued", issued, (i == 5));
        end
        tick(); mem_done = 1'b0; #3;
        chk("mem_after_valid", opcode_valid, 1'b0);
        chk("mem_stall_cnt", stall_cnt, EXP_STALL4);

        // Full queue while stalled
        pushWord(6'h23);
        tick(); instr_valid = 1'b0; #3;
        tick(); #3;
        chk("full_issue_op", opcode, 6'h23);
        offered = 0;
        for (int c = 0; c < 4; c++) begin
            tick(); instr_valid = 1'b1; instr = {6'(offered + 1), 26'd0}; #3;
            if (instr_ready) offered++;
        end
        tick(); #3;
        chk("full_accepted", offered, 3);
        chk("full_count", q_count, 3'd4);
        chk("full_ready", instr_ready, 1'b0);
        tick(); mem_done = 1'b1; #3;
        chk("full_done_iss", issued, 1'b1);
        chk("full_done_ready", instr_ready, 1'b0);
        tick(); mem_done = 1'b0; instr_valid = 1'b0; #3;
        chk("full_after_count", q_count, 3'd3);
        chk("full_after_ready", instr_ready, 1'b1);
        chk("full_next_op", opcode, 6'h01);
        waitIdle("full_drain");

        // Flush during MEM_WAIT with a word on offer
        setupMemWait3();
        tick(); flush = 1'b1; instr_valid = 1'b1; instr = {6'h07, 26'd0}; #3;
        chk("flush_ready", instr_ready, 1'b0);
        chk("flush_iss", issued, 1'b0);
        tick(); flush = 1'b0; instr_valid = 1'b0; mem_done = 1'b1; #3;
        chk("flush_count", q_count, 3'd0);
        chk("flush_valid", opcode_valid, 1'b0);
        chk("flush_late_done", issued, 1'b0);
        tick(); mem_done = 1'b0; #3;
        chk("flush_stays", q_count, 3'd0);

        // Reset mid-operation
        setupMemWait3();
        tick(); rst = 1'b1; #1;
        chk("rstmid_opcode", opcode, 6'h3F);
        chk("rstmid_valid", opcode_valid, 1'b0);
        chk("rstmid_count", q_count, 3'd0);
        chk("rstmid_iss", issued, 1'b0);
        chk("rstmid_ready", instr_ready, 1'b1);
        chk("rstmid_stall", stall_cnt, 16'd0);
        #1 rst = 1'b0;

        // Vector table streamed through a scoreboard
        idx = 0; hold = 0; cyc = 0;
        while ((idx < 8 || sb.size() > 0 || opcode_valid) && cyc < 500) begin
            tick();
            cyc++;
            instr_valid = (idx < 8);
            if (idx < 8) instr = {vecs[idx].op, 26'($urandom)};
            mem_done = opcode_valid && (sb.size() > 0) && (sb[0].lat > 0) && (hold == sb[0].lat);
            #3;
            if (instr_valid && instr_ready) begin
                sb.push_back(vecs[idx]);
                idx++;
            end
            if (issued) begin
                if (sb.size() == 0) begin
                    chk("tbl_spurious_issue", {26'd0, opcode}, 32'hFFFFFFFF);
                end else begin
                    chk("tbl_issue_op", opcode, sb[0].op);
                    chk("tbl_issue_hold", hold + 1, sb[0].expHold);
                    void'(sb.pop_front());
                end
                hold = 0;
            end else if (opcode_valid) begin
                hold++;
            end
        end
        instr_valid = 1'b0; mem_done = 1'b0;
        chk("tbl_complete", {31'd0, (idx == 8) && (sb.size() == 0)}, 32'd1);

        // Long stall for counter saturation
        pushWord(6'h23);
        tick(); instr_valid = 1'b0; #3;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        #3;
        chk("sat_value", stall_cnt, EXP_SAT);
        chk("sat_holding_op", opcode, 6'h23);
        tick(); tick(); tick(); #3;
        chk("sat_stays", stall_cnt, EXP_SAT);
        tick(); mem_done = 1'b1; #3;
        chk("sat_done_iss", issued, 1'b1);
        tick(); mem_done = 1'b0; #3;
        waitIdle("sat_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
